// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a range of register-file indices and streams each
// register as a framed byte sequence (index byte, then data MSB first) on valid/ready.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int NBYTES  = DATA_W / 8;
    localparam int CNT_W   = $clog2(NBYTES + 1);
    localparam int SHIFT_W = DATA_W + 8;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES);
    localparam logic [ADDR_W-1:0] MAX_IDX   = ADDR_W'(NUM_REGS - 1);

    // Stream handshake: a byte moves on a rising edge where tx_valid && tx_ready;
    // tx_valid/tx_data come straight from flops and hold until that edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]    last_q, last_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;

        tx_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        rd_addr  = '0;
        tx_data  = shift_q[SHIFT_W-1 -: 8];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = first_reg;
                    last_d  = last_reg;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy       = 1'b1;
                rd_addr    = idx_q;
                // The snapshot: rd_data is frozen here, later writes do not leak into the frame.
                shift_d    = {8'(idx_q), rd_data};
                byte_cnt_d = '0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                if (tx_ready) begin
                    shift_d    = {shift_q[SHIFT_W-9:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        if (idx_q == last_q) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = (idx_q == MAX_IDX) ? '0 : idx_q + 1'b1;
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
